// File: rtl/aes_pkg.sv
// Shared AES primitives: S-box, GF(2^8) helpers, key-size derivations
// and the types used by the iterative encryption core.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        READY,
        ROUND,
        DONE
    } aes_fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t subword(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One MixColumns column; byte 0 of the column sits in bits [31:24].
    function automatic word_t mixcol(input word_t c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round: SubBytes, ShiftRows,
// MixColumns (bypassed on the final round) and AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         is_final_i,
    output logic [127:0] next_o
);

    logic [7:0]   sb [16];
    logic [127:0] sr;
    logic [127:0] mc;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            assign sb[gi] = sbox(state_i[127-8*gi -: 8]);
            // Byte at row r, column c comes from column (c + r) mod 4 of the same row.
            assign sr[127-8*gi -: 8] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
        end
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign mc[127-32*gi -: 32] = mixcol(sr[127-32*gi -: 32]);
        end
    endgenerate

    assign next_o = (is_final_i ? sr : mc) ^ rk_i;

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES encryptor: expands the key once into a round-key store,
// then encrypts blocks at one round per clock with valid/ready channels.
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [127:0]        pt_in,
    input  logic                pt_valid,
    output logic                pt_ready,
    output logic [127:0]        ct_out,
    output logic                ct_valid,
    input  logic                ct_ready
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = 4 * (NR + 1);
    localparam int RI = $clog2(NR + 1);
    localparam int WI = RI + 2;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_iter: KEY_BITS must be 128, 192 or 256");
    end

    aes_fsm_t      fsm_q, fsm_d;
    logic [WI-1:0] widx_q, widx_d;
    logic [2:0]    kmod_q, kmod_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [RI-1:0] round_q, round_d;
    state_t        st_q, st_d;
    state_t        ct_q, ct_d;
    word_t         rk_q [NW];

    word_t         key_words [NK];
    word_t         w_prev, w_back, w_temp, w_new;
    logic [RI-1:0] rk_idx;
    state_t        rk_cur;
    state_t        round_out;
    logic          key_fire, pt_fire, is_final;

    genvar gi;
    generate
        for (gi = 0; gi < NK; gi++) begin : g_key_words
            assign key_words[gi] = key_in[KEY_BITS-1-32*gi -: 32];
        end
        // The round-key index is forced to 0 outside ROUND so READY sees rk[0] for whitening.
        for (gi = 0; gi < 4; gi++) begin : g_rk_read
            assign rk_cur[127-32*gi -: 32] = rk_q[{rk_idx, 2'(gi)}];
        end
    endgenerate

    assign key_ready = (fsm_q == IDLE) || (fsm_q == READY);
    assign pt_ready  = (fsm_q == READY) && !key_valid;
    assign ct_valid  = (fsm_q == DONE);
    assign ct_out    = ct_q;
    assign key_fire  = key_valid && key_ready;
    assign pt_fire   = pt_valid && pt_ready;
    assign rk_idx    = (fsm_q == ROUND) ? round_q : '0;
    assign is_final  = (round_q == RI'(NR));

    aes_round_comb u_round (
        .state_i    (st_q),
        .rk_i       (rk_cur),
        .is_final_i (is_final),
        .next_o     (round_out)
    );

    // Key schedule: one new word per cycle from w[i-1] and w[i-NK].
    always_comb begin
        w_prev = rk_q[widx_q - WI'(1)];
        w_back = rk_q[widx_q - WI'(NK)];
        w_temp = w_prev;
        if (kmod_q == 3'd0) begin
            w_temp = subword({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h0};
        end else if (NK == 8 && kmod_q == 3'd4) begin
            w_temp = subword(w_prev);
        end
        w_new = w_back ^ w_temp;
    end

    always_comb begin
        fsm_d   = fsm_q;
        widx_d  = widx_q;
        kmod_d  = kmod_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        st_d    = st_q;
        ct_d    = ct_q;
        case (fsm_q)
            IDLE, READY: begin
                if (key_fire) begin
                    fsm_d  = KEYEXP;
                    widx_d = WI'(NK);
                    kmod_d = 3'd0;
                    rcon_d = 8'h01;
                end else if (pt_fire) begin
                    fsm_d   = ROUND;
                    st_d    = pt_in ^ rk_cur;
                    round_d = RI'(1);
                end
            end
            KEYEXP: begin
                widx_d = widx_q + WI'(1);
                kmod_d = (kmod_q == 3'(NK - 1)) ? 3'd0 : kmod_q + 3'd1;
                if (kmod_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (widx_q == WI'(NW - 1)) begin
                    fsm_d = READY;
                end
            end
            ROUND: begin
                st_d    = round_out;
                round_d = round_q + RI'(1);
                if (is_final) begin
                    ct_d  = round_out;
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (ct_ready) begin
                    fsm_d = READY;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            widx_q  <= '0;
            kmod_q  <= '0;
            rcon_q  <= 8'h01;
            round_q <= '0;
            st_q    <= '0;
            ct_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            widx_q  <= widx_d;
            kmod_q  <= kmod_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
            st_q    <= st_d;
            ct_q    <= ct_d;
        end
    end

    // Store contents need no reset: they are only read once KEYEXP has rewritten them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (key_fire) begin
                for (int k = 0; k < NK; k++) begin
                    rk_q[k] <= key_words[k];
                end
            end else if (fsm_q == KEYEXP) begin
                rk_q[widx_q] <= w_new;
            end
        end
    end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter with one core per key size sharing clock and reset.
module tb_aes_enc_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key_in_v;
    logic [127:0] pt_in;
    logic         ct_ready;
    logic         kv [3];
    logic         pv [3];
    logic         kr [3];
    logic         pr [3];
    logic         cv [3];
    logic [127:0] ct_o [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_enc_iter #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .key_in(key_in_v[255:128]), .key_valid(kv[0]), .key_ready(kr[0]),
        .pt_in(pt_in), .pt_valid(pv[0]), .pt_ready(pr[0]),
        .ct_out(ct_o[0]), .ct_valid(cv[0]), .ct_ready(ct_ready)
    );
    aes_enc_iter #(.KEY_BITS(192)) dut192 (
        .clk(clk), .rst(rst), .key_in(key_in_v[255:64]), .key_valid(kv[1]), .key_ready(kr[1]),
        .pt_in(pt_in), .pt_valid(pv[1]), .pt_ready(pr[1]),
        .ct_out(ct_o[1]), .ct_valid(cv[1]), .ct_ready(ct_ready)
    );
    aes_enc_iter #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .key_in(key_in_v), .key_valid(kv[2]), .key_ready(kr[2]),
        .pt_in(pt_in), .pt_valid(pv[2]), .pt_ready(pr[2]),
        .ct_out(ct_o[2]), .ct_valid(cv[2]), .ct_ready(ct_ready)
    );

    // Independent AES-128 reference: S-box derived from GF(2^8) inverse plus affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {ref_sbox(tmp[23:16]), ref_sbox(tmp[15:8]), ref_sbox(tmp[7:0]), ref_sbox(tmp[31:24])}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) t[k] = ref_sbox(s[(k%4) + 4*(((k/4) + (k%4)) % 4)]);
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) begin
                    if (r < 10)
                        s[4*c+j] = gmul(t[4*c+j], 8'h02) ^ gmul(t[4*c+(j+1)%4], 8'h03)
                                   ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
                    else
                        s[4*c+j] = t[4*c+j];
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    task automatic load_key(input int d, input logic [255:0] k, output logic kr_before, output int n);
        key_in_v = k; kv[d] = 1'b1;
        #1;
        kr_before = kr[d];
        @(posedge clk); #1;
        kv[d] = 1'b0;
        n = 0;
        while (kr[d] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic encrypt(input int d, input logic [127:0] pt, output logic pr_seen, output int lat,
                           output logic [127:0] ct, output logic cv_after, output logic kr_after);
        pt_in = pt; pv[d] = 1'b1; ct_ready = 1'b1;
        #1;
        pr_seen = pr[d];
        @(posedge clk); #1;
        pv[d] = 1'b0;
        lat = 1;
        while (cv[d] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ct = ct_o[d];
        @(posedge clk); #1;
        cv_after = cv[d];
        kr_after = kr[d];
    endtask

    task automatic test_reset();
        rst = 1'b1; ct_ready = 1'b1; key_in_v = '0; pt_in = '0;
        for (int d = 0; d < 3; d++) begin kv[d] = 1'b0; pv[d] = 1'b0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++; if (kr[d] !== 1'b1) begin errors++; $display("FAIL reset_key_ready[%0d]: got %b want 1", d, kr[d]); end
            checks++; if (pr[d] !== 1'b0) begin errors++; $display("FAIL reset_pt_ready[%0d]: got %b want 0", d, pr[d]); end
            checks++; if (cv[d] !== 1'b0) begin errors++; $display("FAIL reset_ct_valid[%0d]: got %b want 0", d, cv[d]); end
            checks++; if (ct_o[d] !== 128'h0) begin errors++; $display("FAIL reset_ct_out[%0d]: got %h want 0", d, ct_o[d]); end
        end
    endtask

    task automatic test_vector128();
        logic krb, prs, cva, kra; int n, lat; logic [127:0] ct;
        load_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, krb, n);
        checks++; if (krb !== 1'b1) begin errors++; $display("FAIL v128_key_ready: got %b want 1", krb); end
        checks++; if (n !== 40) begin errors++; $display("FAIL v128_keyexp_cycles: got %0d want 40", n); end
        encrypt(0, 128'h00112233445566778899aabbccddeeff, prs, lat, ct, cva, kra);
        checks++; if (prs !== 1'b1) begin errors++; $display("FAIL v128_pt_ready: got %b want 1", prs); end
        checks++; if (lat !== 11) begin errors++; $display("FAIL v128_latency: got %0d want 11", lat); end
        checks++; if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL v128_ct: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", ct); end
        checks++; if (cva !== 1'b0 || kra !== 1'b1) begin errors++; $display("FAIL v128_after: got ct_valid=%b key_ready=%b want 0 1", cva, kra); end
        $display("v128: key 000102..0f pt 00112233.. -> ct %h latency %0d keyexp %0d", ct, lat, n);
    endtask

    task automatic test_hold();
        int n, bad;
        ct_ready = 1'b0; pt_in = 128'h00112233445566778899aabbccddeeff; pv[0] = 1'b1;
        #1;
        @(posedge clk); #1;
        pv[0] = 1'b0;
        n = 1;
        while (cv[0] !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 11) begin errors++; $display("FAIL hold_latency: got %0d want 11", n); end
        pt_in = 128'hdeadbeefdeadbeefdeadbeefdeadbeef; pv[0] = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (cv[0] !== 1'b1 || ct_o[0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || pr[0] !== 1'b0 || kr[0] !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
        checks++; if (ct_o[0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL hold_ct: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", ct_o[0]); end
        pv[0] = 1'b0; ct_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (cv[0] !== 1'b0 || kr[0] !== 1'b1 || pr[0] !== 1'b1) begin errors++; $display("FAIL hold_release: got ct_valid=%b key_ready=%b pt_ready=%b want 0 1 1", cv[0], kr[0], pr[0]); end
        $display("hold: 20 cycles with ct_ready=0, bad cycles %0d", bad);
    endtask

    task automatic test_simultaneous();
        int n, lat; logic prs, cva, kra; logic [127:0] ct;
        key_in_v = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}; kv[0] = 1'b1;
        pt_in = 128'h3243f6a8885a308d313198a2e0370734; pv[0] = 1'b1;
        #1;
        checks++; if (pr[0] !== 1'b0) begin errors++; $display("FAIL simul_pt_ready: got %b want 0", pr[0]); end
        @(posedge clk); #1;
        kv[0] = 1'b0; pv[0] = 1'b0;
        checks++; if (kr[0] !== 1'b0) begin errors++; $display("FAIL simul_key_taken: got key_ready=%b want 0", kr[0]); end
        n = 0;
        while (kr[0] !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 40) begin errors++; $display("FAIL simul_keyexp_cycles: got %0d want 40", n); end
        encrypt(0, 128'h3243f6a8885a308d313198a2e0370734, prs, lat, ct, cva, kra);
        checks++; if (ct !== 128'h3925841d02dc09fbdc118597196a0b32) begin errors++; $display("FAIL simul_ct: got %h want 3925841d02dc09fbdc118597196a0b32", ct); end
        $display("simul: rekey 2b7e.. pt 3243f6a8.. -> ct %h", ct);
    endtask

    task automatic test_same_key();
        int lat; logic prs, cva, kra; logic [127:0] ct, exp_ct;
        exp_ct = ref_aes128(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h00112233445566778899aabbccddeeff);
        encrypt(0, 128'h00112233445566778899aabbccddeeff, prs, lat, ct, cva, kra);
        checks++; if (ct !== exp_ct) begin errors++; $display("FAIL samekey_ct: got %h want %h", ct, exp_ct); end
        checks++; if (prs !== 1'b1) begin errors++; $display("FAIL samekey_pt_ready: got %b want 1", prs); end
        $display("samekey: key 2b7e.. pt 00112233.. -> ct %h", ct);
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [3];
        logic [127:0] cts [3];
        int acc [3];
        int n;
        pts[0] = 128'h6bc1bee22e409f96e93d7e117393172a; cts[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        pts[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; cts[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        pts[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; cts[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        ct_ready = 1'b1; pv[0] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            pt_in = pts[b];
            #1;
            n = 0;
            while (pr[0] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            acc[b] = cyc;
            @(posedge clk); #1;
            n = 0;
            while (cv[0] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            checks++; if (ct_o[0] !== cts[b]) begin errors++; $display("FAIL b2b_ct[%0d]: got %h want %h", b, ct_o[0], cts[b]); end
            $display("b2b: block %0d pt %h -> ct %h accepted at cycle %0d", b, pts[b], ct_o[0], acc[b]);
            if (b == 2) pv[0] = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (acc[1] - acc[0] !== 12) begin errors++; $display("FAIL b2b_period01: got %0d want 12", acc[1] - acc[0]); end
        checks++; if (acc[2] - acc[1] !== 12) begin errors++; $display("FAIL b2b_period12: got %0d want 12", acc[2] - acc[1]); end
    endtask

    task automatic test_key192();
        logic krb, prs, cva, kra; int n, lat; logic [127:0] ct;
        load_key(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, krb, n);
        checks++; if (n !== 46) begin errors++; $display("FAIL k192_keyexp_cycles: got %0d want 46", n); end
        encrypt(1, 128'h00112233445566778899aabbccddeeff, prs, lat, ct, cva, kra);
        checks++; if (lat !== 13) begin errors++; $display("FAIL k192_latency: got %0d want 13", lat); end
        checks++; if (ct !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191) begin errors++; $display("FAIL k192_ct: got %h want dda97ca4864cdfe06eaf70a0ec0d7191", ct); end
        $display("k192: ct %h latency %0d keyexp %0d", ct, lat, n);
    endtask

    task automatic test_key256();
        logic krb, prs, cva, kra; int n, lat; logic [127:0] ct;
        load_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, krb, n);
        checks++; if (n !== 52) begin errors++; $display("FAIL k256_keyexp_cycles: got %0d want 52", n); end
        encrypt(2, 128'h00112233445566778899aabbccddeeff, prs, lat, ct, cva, kra);
        checks++; if (lat !== 15) begin errors++; $display("FAIL k256_latency: got %0d want 15", lat); end
        checks++; if (ct !== 128'h8ea2b7ca516745bfeafc49904b496089) begin errors++; $display("FAIL k256_ct: got %h want 8ea2b7ca516745bfeafc49904b496089", ct); end
        $display("k256: ct %h latency %0d keyexp %0d", ct, lat, n);
    endtask

    task automatic test_reset_midop();
        int bad;
        ct_ready = 1'b1; pt_in = 128'h00112233445566778899aabbccddeeff; pv[0] = 1'b1;
        #1;
        @(posedge clk); #1;
        pv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (cv[0] !== 1'b0) begin errors++; $display("FAIL midrst_ct_valid: got %b want 0", cv[0]); end
        checks++; if (ct_o[0] !== 128'h0) begin errors++; $display("FAIL midrst_ct_out: got %h want 0", ct_o[0]); end
        checks++; if (kr[0] !== 1'b1) begin errors++; $display("FAIL midrst_key_ready: got %b want 1", kr[0]); end
        checks++; if (pr[0] !== 1'b0) begin errors++; $display("FAIL midrst_pt_ready: got %b want 0", pr[0]); end
        pv[0] = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (pr[0] !== 1'b0 || cv[0] !== 1'b0 || kr[0] !== 1'b1) bad++;
        end
        pv[0] = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_no_accept: got %0d bad cycles want 0", bad); end
        $display("midrst: reset at round 5, bad cycles while offering pt %0d", bad);
    endtask

    initial begin
        test_reset();
        test_vector128();
        test_hold();
        test_simultaneous();
        test_same_key();
        test_back_to_back();
        test_key192();
        test_key256();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_enc_iter.md
Name: aes_enc_iter

Overview:
Iterative AES encryption core, parametrised for 128/192/256-bit keys. It expands a loaded key once into an on-chip round-key store, then encrypts any number of 128-bit blocks under that key at one round per clock. All three channels (key, plaintext, ciphertext) use valid/ready handshakes. It replaces fully-unrolled combinational encryption where area matters and a multi-cycle latency is acceptable.

Parameters:
KEY_BITS, 128, key length; legal values 128/192/256; any other value is an elaboration error. Derived: NK=KEY_BITS/32, NR=NK+6.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
key_in  in  KEY_BITS  cipher key; bits [KEY_BITS-1 -: 32] = w[0]
key_valid  in  1  key offered
key_ready  out  1  core accepts key (state IDLE or READY)
pt_in  in  128  plaintext; bits [127:120] = byte 0 (FIPS-197 order)
pt_valid  in  1  plaintext offered
pt_ready  out  1  core accepts plaintext
ct_out  out  128  ciphertext, same byte order as pt_in
ct_valid  out  1  ciphertext valid
ct_ready  in  1  sink accepts ciphertext

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset, including mid-operation: FSM to IDLE; key store marked invalid; ct_valid=0; ct_out=0; pt_ready=0; key_ready=1 in the first cycle after reset. Any in-flight block is discarded.
- FSM states: IDLE, KEYEXP, READY, ROUND, DONE.
- IDLE: key_ready=1, pt_ready=0. A key handshake goes to KEYEXP.
- KEYEXP:
  - Edge of the handshake: w[0..NK-1] <- key_in; rcon <- 8'h01.
  - Each following cycle computes one word w[i], i = NK .. 4*(NR+1)-1.
  - temp = w[i-1]. If i%NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <- xtime(rcon). Else if NK==8 and i%NK==4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - Duration is 4*(NR+1)-NK cycles (40 / 46 / 52). Then go to READY.
  - key_ready=0 and pt_ready=0 throughout.
- READY:
  - key_ready=1; pt_ready = !key_valid, so a simultaneous key offer wins and the plaintext is not accepted.
  - Key handshake goes to KEYEXP (re-key).
  - Plaintext handshake: state <- pt_in ^ rk0; round <- 1; go to ROUND.
- ROUND:
  - Each cycle: state <- AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[round]); MixColumns is skipped when round==NR.
  - After round NR, latch ct_out and go to DONE.
  - key_ready=0, pt_ready=0.
- DONE:
  - ct_valid=1. ct_out is held stable until ct_ready=1.
  - Handshake returns to READY; ct_valid drops the next cycle. The key is retained.
- Latency: ct_valid rises NR+1 cycles after the plaintext handshake cycle (11 / 13 / 15).
- Throughput: one block per NR+2 cycles when ct_ready is held at 1.
- Inputs are ignored while the matching ready signal is 0. ct_out keeps its last value outside DONE.
- Round-key store: 4*(NR+1) x 32-bit registers. rk[r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.

Decomposition:
- Package aes_pkg:
  - S-box constant array and sbox() function
  - xtime() and mixcol() functions
  - nk_of() and nr_of() functions of KEY_BITS
  - FSM state enum typedef
  - state_t (logic [127:0]) and word_t (logic [31:0]) typedefs
- Sub-module aes_round_comb (combinational): inputs state, rk, is_final; output next state.
- The key schedule's SubWord reuses sbox() from the package.

Test Plan:
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a. key_ready low for 40 cycles; ct_valid 11 cycles after the pt handshake.
- KEY_BITS=192, key 000102…1617, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191. KEY_BITS=256, key 000102…1e1f -> 8ea2b7ca516745bfeafc49904b496089.
- KEY_BITS=128: load key 2b7e151628aed2a6abf7158809cf4f3c and encrypt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Then, without re-keying, encrypt the Appendix C pt under this key and check it against a reference model.
- Hold ct_ready=0 for 20 cycles in DONE -> ct_out and ct_valid stable, pt_ready=0, key_ready=0. Release ct_ready -> READY next cycle.
- In READY, assert key_valid and pt_valid together -> pt_ready=0 and the key is loaded. The next encryption uses the new key.
- Assert rst at round 5 -> next cycle ct_valid=0, ct_out=0, key_ready=1, pt_ready=0. A plaintext offered before a new key is never accepted.
